bus_master_arbiter: RTL
=======================

// Module: bus_master_arbiter
// PURPOSE
// - Shares the single dValid/dAck/data bus between N_REQ requesters, using round-robin arbitration.
// - Sequences each transfer so the bus obeys the protocol:
//   - dValid is high for MIN_BEATS..MAX_BEATS clocks.
//   - data stays stable until dAck.
//   - dValid drops the clock after dAck.
// - Sits between the local request sources and the bus target.
// PARAMETERS
// - N_REQ      4  number of requesters (2..8)
// - DATA_W     8  bus data width
// - MIN_BEATS  2  minimum dValid-high clocks (dAck ignored before beat MIN_BEATS-1)
// - MAX_BEATS  4  maximum dValid-high clocks (forced de-assert at beat MAX_BEATS)
// PORTS
// - clk         in   1             single clock, all flops rising-edge
// - reset       in   1             asynchronous, active-high reset
// - req_i       in   N_REQ         request per requester, held until ack_o or nack_o
// - req_data_i  in   N_REQ*DATA_W  packed data, slice k belongs to requester k
// - dAck        in   1             target accept, from bus
// - dValid      out  1             bus valid, registered
// - data        out  DATA_W        bus data, registered
// - ack_o       out  N_REQ         one-hot 1-clk pulse: owner's transfer accepted
// - nack_o      out  N_REQ         one-hot 1-clk pulse: owner's transfer timed out
// - early_ack_o out  1             1-clk pulse: dAck seen before beat MIN_BEATS-1 (ignored)
// - busy_o      out  1             high while in XFER
// BEHAVIOUR
// - Reset (async): outputs and state go to reset values immediately, even mid-transfer.
//   - State: state=IDLE, beat=0, rr_ptr=0.
//   - Outputs: dValid=0, data=0, ack_o=0, nack_o=0, early_ack_o=0, busy_o=0.
// - States: IDLE, XFER. beat counter is $clog2(MAX_BEATS) bits and counts beats 0..MAX_BEATS-1.
// - IDLE, no req_i: outputs hold, dValid=0.
// - IDLE, any req_i:
//   - Winner = first set bit at or after rr_ptr, wrapping modulo N_REQ.
//   - Same edge: data<=winner slice, dValid<=1, owner<=winner, beat<=0, rr_ptr<=(winner+1)%N_REQ, go XFER.
// - XFER, every edge, first matching rule applies:
//   - dAck && beat>=MIN_BEATS-1 -> dValid<=0, ack_o[owner] pulse, go IDLE.
//   - dAck && beat<MIN_BEATS-1 -> early_ack_o pulse; dAck is ignored and the next rule is evaluated.
//   - beat==MAX_BEATS-1 -> dValid<=0, nack_o[owner] pulse, go IDLE. Requester may re-request.
//   - otherwise -> beat<=beat+1.
// - data is frozen for the whole XFER. req_i/req_data_i changes during XFER are not sampled.
// - Latency:
//   - req to dValid: 1 clk from IDLE.
//   - dAck to dValid low: 1 clk.
//   - dAck to ack_o: 1 clk.
// - Gaps:
//   - dValid is low for at least 1 clk between transfers, so every transfer shows $rose(dValid).
//   - Back-to-back requests give exactly 1 low clk between transfers.
// - dAck while IDLE: ignored, no flag.
// - Simultaneous dAck and beat==MAX_BEATS-1: the ack wins (ack_o, not nack_o).
// - A requester dropping req_i mid-XFER has no effect. The transfer completes normally.
// - rr_ptr wraps N_REQ-1 -> 0.
// - With a single requester, that requester is re-granted on every IDLE visit.
// STRUCTURE
// - bus_protocol_pkg: DATA_W, MIN_BEATS, MAX_BEATS defaults; state enum typedef (IDLE, XFER).
// - Sub-module rr_arbiter:
//   - Interface: req, ptr in; one-hot gnt and index out.
//   - Purely combinational; the pointer register lives in the top.
// - Top: FSM, beat counter, data/owner registers, pulse outputs.
// - Bind the existing bus protocol property checks (valid length, data stable, dAck window) to the bus outputs.
// TESTING
// 1. Single transfer:
//    - Stimulus: req_i=0001, data0=8'hA5; dAck at beat 1.
//    - Response: dValid high 2 clks, data=A5 throughout, ack_o=0001 one clk later.
// 2. Late ack:
//    - Stimulus: dAck at beat 3.
//    - Response: dValid high 4 clks, ack_o pulse, no nack_o.
// 3. Timeout:
//    - Stimulus: no dAck.
//    - Response: dValid high 4 clks, then low; nack_o=owner pulse.
// 4. Early ack:
//    - Stimulus: dAck at beat 0 only, then again at beat 2.
//    - Response: early_ack_o pulse at beat 0; dValid high 3 clks; ack_o pulse.
// 5. Round-robin:
//    - Stimulus: req_i=1111 held; each transfer acked at beat 1.
//    - Response: grants 0,1,2,3,0; 1 low clk between transfers; distinct data per grant.
// 6. Reset mid-XFER:
//    - Stimulus: assert reset at beat 2.
//    - Response: dValid=0 before the next edge, no ack_o/nack_o, rr_ptr=0; after release req_i=0100 is granted first.

Source files
------------

// File: rtl/bus_master_arbiter_pkg.sv
// Shared defaults and types for the round-robin bus master arbiter.
// The transfer FSM has two states: waiting for a request, or driving a transfer.
package bus_protocol_pkg;

   localparam int N_REQ_DEF     = 4;
   localparam int DATA_W_DEF    = 8;
   localparam int MIN_BEATS_DEF = 2;
   localparam int MAX_BEATS_DEF = 4;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   // Width of a counter holding beats 0..max_beats-1 (never narrower than 1 bit).
   function automatic int beat_w(input int max_beats);
      return (max_beats > 1) ? $clog2(max_beats) : 1;
   endfunction

endpackage

// File: rtl/bus_master_arbiter_if.sv
// dValid/dAck/data bus between the arbiter (master) and the bus target (slave),
// carrying the protocol property checks for whoever drives it.
interface bus_master_arbiter_if
   import bus_protocol_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MIN_BEATS = MIN_BEATS_DEF,
   parameter int MAX_BEATS = MAX_BEATS_DEF
) (
   input logic clk,
   input logic reset
);

   logic              dValid;
   logic              dAck;
   logic [DATA_W-1:0] data;

   modport master (output dValid, output data, input dAck);
   modport slave  (input dValid, input data, output dAck);

   localparam logic [7:0] MIN_C = 8'(MIN_BEATS);
   localparam logic [7:0] MAX_C = 8'(MAX_BEATS);

   // hi_cnt equals the beat index whenever dValid is sampled high
   logic [7:0] hi_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) hi_cnt <= '0;
      else       hi_cnt <= dValid ? hi_cnt + 8'd1 : 8'd0;
   end

   a_valid_max : assert property (@(posedge clk) disable iff (reset)
      dValid |-> (hi_cnt < MAX_C));

   a_valid_min : assert property (@(posedge clk) disable iff (reset)
      $fell(dValid) |-> (hi_cnt >= MIN_C));

   a_data_stable : assert property (@(posedge clk) disable iff (reset)
      (dValid && $past(dValid)) |-> (data == $past(data)));

   a_ack_window : assert property (@(posedge clk) disable iff (reset)
      (dValid && dAck && (hi_cnt >= MIN_C - 8'd1)) |=> !dValid);

endinterface

// File: rtl/bus_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_arbiter
   import bus_protocol_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] idx
);

   int   k;
   logic found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         k = (int'(ptr) + i) % N_REQ;
         if (!found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/bus_master_arbiter.sv
// Round-robin master for a shared dValid/dAck/data bus: grants one requester,
// holds its data for MIN_BEATS..MAX_BEATS clocks and reports ack or timeout.
module bus_master_arbiter
   import bus_protocol_pkg::*;
#(
   parameter int N_REQ     = N_REQ_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MIN_BEATS = MIN_BEATS_DEF,
   parameter int MAX_BEATS = MAX_BEATS_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_i,
   input  logic [N_REQ*DATA_W-1:0] req_data_i,
   bus_master_arbiter_if.master    bus,
   output logic [N_REQ-1:0]        ack_o,
   output logic [N_REQ-1:0]        nack_o,
   output logic                    early_ack_o,
   output logic                    busy_o
);

   localparam int IDX_W  = $clog2(N_REQ);
   localparam int BEAT_W = beat_w(MAX_BEATS);
   localparam logic [BEAT_W-1:0] ACK_BEAT  = BEAT_W'(MIN_BEATS - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);

   state_t              state_q, state_n;
   logic [BEAT_W-1:0]   beat_q, beat_n;
   logic [IDX_W-1:0]    owner_q, owner_n;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_n;
   logic                dvalid_q, dvalid_n;
   logic [DATA_W-1:0]   data_q, data_n;
   logic [N_REQ-1:0]    ack_n, nack_n;
   logic                early_n;
   logic [N_REQ-1:0]    arb_gnt;
   logic [IDX_W-1:0]    arb_idx;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req (req_i),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   always_comb begin
      state_n  = state_q;
      beat_n   = beat_q;
      owner_n  = owner_q;
      rr_ptr_n = rr_ptr_q;
      dvalid_n = dvalid_q;
      data_n   = data_q;
      ack_n    = '0;
      nack_n   = '0;
      early_n  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|arb_gnt) begin
               state_n  = XFER;
               dvalid_n = 1'b1;
               data_n   = req_data_i[arb_idx*DATA_W +: DATA_W];
               owner_n  = arb_idx;
               beat_n   = '0;
               rr_ptr_n = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
            end
         end
         XFER: begin
            if (bus.dAck && beat_q >= ACK_BEAT) begin
               state_n         = IDLE;
               dvalid_n        = 1'b0;
               ack_n[owner_q]  = 1'b1;
            end else begin
               // An ack arriving too early is flagged and otherwise ignored
               early_n = bus.dAck;
               if (beat_q == LAST_BEAT) begin
                  state_n         = IDLE;
                  dvalid_n        = 1'b0;
                  nack_n[owner_q] = 1'b1;
               end else begin
                  beat_n = beat_q + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         dvalid_q    <= 1'b0;
         data_q      <= '0;
         ack_o       <= '0;
         nack_o      <= '0;
         early_ack_o <= 1'b0;
      end else begin
         state_q     <= state_n;
         beat_q      <= beat_n;
         owner_q     <= owner_n;
         rr_ptr_q    <= rr_ptr_n;
         dvalid_q    <= dvalid_n;
         data_q      <= data_n;
         ack_o       <= ack_n;
         nack_o      <= nack_n;
         early_ack_o <= early_n;
      end
   end

   assign bus.dValid = dvalid_q;
   assign bus.data   = data_q;
   assign busy_o     = (state_q == XFER);

endmodule
